// File: rtl/apb_completer_pkg.sv
// Shared definitions for the APB completer.
//   state_e       : one-hot FSM encoding, matching the requester bridge
//   ApbAddrWidth  : default APB address width
//   ApbDataWidth  : default APB data width
//   CntWidth      : wait-state counter width (0..15 wait states)
package apb_completer_pkg;

  localparam int unsigned ApbAddrWidth = 8;
  localparam int unsigned ApbDataWidth = 8;
  localparam int unsigned CntWidth     = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'b01,
    StAccess = 2'b10
  } state_e;

endpackage

// File: rtl/apb_completer_if.sv
// APB bus bundle between a requester (master) and a completer (slave).
//   psel, penable, paddr, pwrite, pwdata : requester -> completer
//   prdata, pready, pslverr              : completer -> requester
interface apb_completer_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_completer_regfile.sv
// Register array for the APB completer.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   we_i/waddr_i/wdata_i : single write port
//   raddr_i/rdata_o  : combinational read port; out-of-range reads return 0
// Register 0 is hardwired to ID_VALUE and has no storage.
module apb_completer_regfile
  import apb_completer_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = ApbAddrWidth,
  parameter int unsigned          DATA_WIDTH = ApbDataWidth,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE  = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  // Full-width address compares: no aliasing above NUM_REGS-1.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (we_i && (waddr_i == ADDR_WIDTH'(i))) regs_d[i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (raddr_i == '0) rdata_o = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (raddr_i == ADDR_WIDTH'(i)) rdata_o = regs_q[i];
    end
  end

endmodule

// File: rtl/apb_completer.sv
// APB completer with a small register file and programmable wait states.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   apb          : APB slave bundle (select/enable/address/data/ready/error)
//   wr_strobe    : one-cycle pulse after a write commits
//   wr_addr      : address of the committed write, valid with wr_strobe
// Errors: address >= NUM_REGS, or a write to the read-only ID register 0.
module apb_completer
  import apb_completer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = ApbAddrWidth,
  parameter int unsigned           DATA_WIDTH  = ApbDataWidth,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_completer_if.slave        apb,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  localparam logic [ADDR_WIDTH:0] NumRegsExt = (ADDR_WIDTH + 1)'(NUM_REGS);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;

  logic                  pready;
  logic                  setup;
  logic                  commit;
  logic                  err_setup;
  logic [DATA_WIDTH-1:0] rf_rdata;

  // Ready depends only on registered state, never on the bus inputs.
  assign pready    = (state_q == StAccess) && (cnt_q == '0);
  assign setup     = (state_q == StIdle) && apb.psel && !apb.penable;
  assign err_setup = ({1'b0, apb.paddr} >= NumRegsExt) || (apb.pwrite && (apb.paddr == '0));
  assign commit    = pready && apb.psel && apb.penable && write_q && !err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    err_d       = err_q;
    prdata_d    = prdata_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    unique case (state_q)
      StIdle: begin
        // ENABLE without a preceding SETUP is ignored here.
        if (setup) begin
          addr_d   = apb.paddr;
          wdata_d  = apb.pwdata;
          write_d  = apb.pwrite;
          err_d    = err_setup;
          cnt_d    = CntWidth'(WAIT_STATES);
          prdata_d = (!apb.pwrite && !err_setup) ? rf_rdata : '0;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (!apb.psel) begin
          state_d = StIdle;  // requester abort, nothing commits
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (apb.penable) begin
          state_d     = StIdle;
          wr_strobe_d = commit;
          if (commit) wr_addr_d = addr_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      err_q       <= err_d;
      prdata_q    <= prdata_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  apb_completer_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .we_i    (commit),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (apb.paddr),
    .rdata_o (rf_rdata)
  );

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready;
  assign apb.pslverr = pready && err_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer. Three instances (0, 3 and 2 wait states)
// share one set of bus drivers; cur selects which instance sees PSEL.
module tb_apb_completer;

  logic       clk;
  logic       rst;
  logic       psel;
  logic       penable;
  logic [7:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  int         cur;

  logic       pready, pslverr, wr_strobe;
  logic [7:0] prdata, wr_addr;
  logic       ws0, ws1, ws2;
  logic [7:0] wa0, wa1, wa2;

  int n_tests = 0;
  int n_fail  = 0;

  apb_completer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();
  apb_completer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();
  apb_completer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus2 ();

  assign bus0.psel = psel && (cur == 0);
  assign bus1.psel = psel && (cur == 1);
  assign bus2.psel = psel && (cur == 2);
  assign bus0.penable = penable;
  assign bus1.penable = penable;
  assign bus2.penable = penable;
  assign bus0.paddr = paddr;
  assign bus1.paddr = paddr;
  assign bus2.paddr = paddr;
  assign bus0.pwrite = pwrite;
  assign bus1.pwrite = pwrite;
  assign bus2.pwrite = pwrite;
  assign bus0.pwdata = pwdata;
  assign bus1.pwdata = pwdata;
  assign bus2.pwdata = pwdata;

  apb_completer #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .apb(bus0), .wr_strobe(ws0), .wr_addr(wa0)
  );
  apb_completer #(.WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESET(rst), .apb(bus1), .wr_strobe(ws1), .wr_addr(wa1)
  );
  apb_completer #(.WAIT_STATES(2)) dut2 (
    .PCLK(clk), .PRESET(rst), .apb(bus2), .wr_strobe(ws2), .wr_addr(wa2)
  );

  always_comb begin
    case (cur)
      1: begin
        pready = bus1.pready; pslverr = bus1.pslverr; prdata = bus1.prdata;
        wr_strobe = ws1; wr_addr = wa1;
      end
      2: begin
        pready = bus2.pready; pslverr = bus2.pslverr; prdata = bus2.prdata;
        wr_strobe = ws2; wr_addr = wa2;
      end
      default: begin
        pready = bus0.pready; pslverr = bus0.pslverr; prdata = bus0.prdata;
        wr_strobe = ws0; wr_addr = wa0;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0;
  endtask

  // Call #1 after a rising edge. Returns #1 after the completion edge with
  // psel/penable still high so another transfer may follow without a gap.
  task automatic xfer(input string tag, input logic [7:0] addr, input logic wr,
                      input logic [7:0] wdata, input int exp_waits,
                      output logic [7:0] rdata, output logic err,
                      output logic strobe, output logic [7:0] waddr);
    int n;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    // Bus lines change during ACCESS; the latched values must be used.
    paddr = ~addr; pwdata = ~wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready) break;
      n++;
      if (n > 20) begin
        check({tag, ".timeout"}, 32'(n), 32'(exp_waits));
        break;
      end
    end
    check({tag, ".waits"}, 32'(n), 32'(exp_waits));
    rdata = prdata;
    err   = pslverr;
    @(posedge clk); #1;
    strobe = wr_strobe;
    waddr  = wr_addr;
  endtask

  logic [7:0] rd, wa;
  logic       er, st;

  initial begin
    cur = 0; rst = 1'b1; pwrite = 1'b0; paddr = '0; pwdata = '0;
    bus_idle();
    #2;
    check("rst.pready",  32'(pready),    32'd0);
    check("rst.pslverr", 32'(pslverr),   32'd0);
    check("rst.prdata",  32'(prdata),    32'd0);
    check("rst.strobe",  32'(wr_strobe), 32'd0);
    check("rst.waddr",   32'(wr_addr),   32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: write then read addr 5.
    xfer("w05", 8'h05, 1'b1, 8'h3C, 0, rd, er, st, wa);
    check("w05.err",    32'(er), 32'd0);
    check("w05.strobe", 32'(st), 32'd1);
    check("w05.waddr",  32'(wa), 32'h05);
    bus_idle();
    @(posedge clk); #1;
    check("w05.strobe_off", 32'(wr_strobe), 32'd0);
    xfer("r05", 8'h05, 1'b0, 8'h00, 0, rd, er, st, wa);
    check("r05.data",   32'(rd), 32'h3C);
    check("r05.err",    32'(er), 32'd0);
    check("r05.strobe", 32'(st), 32'd0);
    bus_idle();
    @(posedge clk); #1;
    check("idle.prdata_hold", 32'(prdata), 32'h3C);

    // Three wait states: ID register read.
    cur = 1;
    xfer("r00w3", 8'h00, 1'b0, 8'h00, 3, rd, er, st, wa);
    check("r00w3.data", 32'(rd), 32'hA5);
    check("r00w3.err",  32'(er), 32'd0);
    bus_idle();
    @(posedge clk); #1;

    // Error responses.
    cur = 0;
    xfer("w20", 8'h20, 1'b1, 8'hFF, 0, rd, er, st, wa);
    check("w20.err",    32'(er), 32'd1);
    check("w20.strobe", 32'(st), 32'd0);
    xfer("w00", 8'h00, 1'b1, 8'h11, 0, rd, er, st, wa);
    check("w00.err",    32'(er), 32'd1);
    check("w00.strobe", 32'(st), 32'd0);
    xfer("r00", 8'h00, 1'b0, 8'h00, 0, rd, er, st, wa);
    check("r00.data", 32'(rd), 32'hA5);
    check("r00.err",  32'(er), 32'd0);
    xfer("r10", 8'h10, 1'b0, 8'h00, 0, rd, er, st, wa);
    check("r10.err",  32'(er), 32'd1);
    check("r10.data", 32'(rd), 32'h00);
    xfer("r0f", 8'h0F, 1'b0, 8'h00, 0, rd, er, st, wa);
    check("r0f.err",  32'(er), 32'd0);
    check("r0f.data", 32'(rd), 32'h00);

    // Back-to-back write then read, no idle cycle.
    xfer("w02", 8'h02, 1'b1, 8'h77, 0, rd, er, st, wa);
    check("w02.strobe", 32'(st), 32'd1);
    check("w02.waddr",  32'(wa), 32'h02);
    xfer("r02", 8'h02, 1'b0, 8'h00, 0, rd, er, st, wa);
    check("r02.data", 32'(rd), 32'h77);
    bus_idle();
    @(posedge clk); #1;

    // Two wait states: abort a write in the second wait cycle.
    cur = 2;
    psel = 1'b1; penable = 1'b0; paddr = 8'h03; pwrite = 1'b1; pwdata = 8'h55;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort.wait1", 32'(pready), 32'd0);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("abort.wait2", 32'(pready), 32'd0);
    @(posedge clk); #1;
    check("abort.strobe", 32'(wr_strobe), 32'd0);
    @(negedge clk);
    check("abort.idle_pready", 32'(pready), 32'd0);
    @(posedge clk); #1;
    check("abort.strobe2", 32'(wr_strobe), 32'd0);
    xfer("r03", 8'h03, 1'b0, 8'h00, 2, rd, er, st, wa);
    check("r03.data", 32'(rd), 32'h00);
    bus_idle();
    @(posedge clk); #1;

    // Async reset mid-ACCESS of an ID read holding PRDATA=A5.
    cur = 1;
    psel = 1'b1; penable = 1'b0; paddr = 8'h00; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    check("rstrd.prdata_pre", 32'(prdata), 32'hA5);
    rst = 1'b1;
    #1;
    check("rstrd.prdata", 32'(prdata), 32'h00);
    bus_idle();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Async reset mid-ENABLE of a write to addr 4.
    cur = 0;
    psel = 1'b1; penable = 1'b0; paddr = 8'h04; pwrite = 1'b1; pwdata = 8'h99;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rstwr.pready",  32'(pready),  32'd0);
    check("rstwr.pslverr", 32'(pslverr), 32'd0);
    check("rstwr.prdata",  32'(prdata),  32'd0);
    @(posedge clk); #1;
    check("rstwr.strobe", 32'(wr_strobe), 32'd0);
    bus_idle();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rstwr.idle", 32'(pready), 32'd0);
    xfer("r04", 8'h04, 1'b0, 8'h00, 0, rd, er, st, wa);
    check("r04.data", 32'(rd), 32'h00);
    check("r04.err",  32'(er), 32'd0);
    bus_idle();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
